// File: rtl/dma_pkg.sv
// Shared types for the DMA dispatcher: FSM encoding, descriptor payload and FIFO depth default.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W                = 64;
    localparam int unsigned DMA_LEN_W                 = 32;
    localparam int unsigned DMA_DESCRIPTOR_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        HALT      = 2'd3
    } t_disp_state;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src;
        logic [DMA_ADDR_W-1:0] dst;
        logic [DMA_LEN_W-1:0]  len;
    } t_dma_desc;

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with flush; flags and level are registered, head is a
// combinational read of the entry at the read pointer.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter  int unsigned DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  t_dma_desc     wdata,
    input  logic          pop,
    output t_dma_desc     head_c,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_next_c
);

    t_dma_desc     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic [LW-1:0] level_d;

    assign push_ok      = push & ~full & ~flush;
    assign pop_ok       = pop & ~empty & ~flush;
    assign head_c       = mem[rd_ptr];
    assign level_next_c = level_d;

    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (push_ok && !pop_ok) begin
            level_d = level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_d;
            empty <= (level_d == '0);
            full  <= (level_d == LW'(DEPTH));
        end
    end

endmodule

// File: rtl/dma_dispatcher.sv
// Buffers descriptors and issues one read + one write command per descriptor, then waits
// for both completions. Optional cycle counter: define DMA_DISPATCHER_PERF_CNTR_EN.
module dma_dispatcher
    import dma_pkg::*;
#(
    parameter  int unsigned ADDR_W     = DMA_ADDR_W,
    parameter  int unsigned LEN_W      = DMA_LEN_W,
    parameter  int unsigned FIFO_DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              desc_go,
    input  logic [ADDR_W-1:0] desc_src,
    input  logic [ADDR_W-1:0] desc_dst,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic              ctl_stop,
    input  logic              ctl_soft_reset,
    input  logic              ctl_stop_on_err,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic              wr_cmd_valid,
    input  logic              wr_cmd_ready,
    output logic [ADDR_W-1:0] cmd_src,
    output logic [ADDR_W-1:0] cmd_dst,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              rd_done,
    input  logic              wr_done,
    input  logic              rd_err,
    input  logic              wr_err,
    output logic              busy,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [CNT_W-1:0]  desc_count,
    output logic              stopped_on_error,
    output logic              overflow,
    output t_disp_state       state
`ifdef DMA_DISPATCHER_PERF_CNTR_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    t_disp_state       state_d;
    logic              rd_vld_d, wr_vld_d;
    logic [ADDR_W-1:0] src_d, dst_d;
    logic [LEN_W-1:0]  len_d;
    logic              rd_flag, wr_flag, err_flag;
    logic              rd_flag_d, wr_flag_d, err_d;
    logic [CNT_W-1:0]  count_d;
    logic              stopped_d, overflow_d, busy_d;
    logic              pop;
    t_dma_desc         wdata;
    t_dma_desc         head_c;
    logic [LVL_W-1:0]  level_next_c;

    always_comb begin
        wdata.src = DMA_ADDR_W'(desc_src);
        wdata.dst = DMA_ADDR_W'(desc_dst);
        wdata.len = DMA_LEN_W'(desc_len);
    end

    dma_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (ctl_soft_reset),
        .push         (desc_go),
        .wdata        (wdata),
        .pop          (pop),
        .head_c       (head_c),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .level        (fifo_level),
        .level_next_c (level_next_c)
    );

    // Next-state and registered-output logic; soft reset overrides everything last.
    always_comb begin
        state_d    = state;
        rd_vld_d   = rd_cmd_valid;
        wr_vld_d   = wr_cmd_valid;
        src_d      = cmd_src;
        dst_d      = cmd_dst;
        len_d      = cmd_len;
        rd_flag_d  = rd_flag;
        wr_flag_d  = wr_flag;
        err_d      = err_flag;
        count_d    = desc_count;
        stopped_d  = stopped_on_error;
        overflow_d = overflow | (desc_go & fifo_full);
        pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty && !ctl_stop && !stopped_on_error) begin
                    pop       = 1'b1;
                    src_d     = ADDR_W'(head_c.src);
                    dst_d     = ADDR_W'(head_c.dst);
                    len_d     = LEN_W'(head_c.len);
                    rd_vld_d  = 1'b1;
                    wr_vld_d  = 1'b1;
                    rd_flag_d = 1'b0;
                    wr_flag_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // An engine may finish before its partner has accepted its command.
                if (!rd_cmd_valid && rd_done) begin
                    rd_flag_d = 1'b1;
                    err_d     = err_d | rd_err;
                end
                if (!wr_cmd_valid && wr_done) begin
                    wr_flag_d = 1'b1;
                    err_d     = err_d | wr_err;
                end
                rd_vld_d = rd_cmd_valid & ~rd_cmd_ready;
                wr_vld_d = wr_cmd_valid & ~wr_cmd_ready;
                if (!rd_vld_d && !wr_vld_d) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rd_done) begin
                    rd_flag_d = 1'b1;
                    err_d     = err_d | rd_err;
                end
                if (wr_done) begin
                    wr_flag_d = 1'b1;
                    err_d     = err_d | wr_err;
                end
                if (rd_flag_d && wr_flag_d) begin
                    count_d = desc_count + CNT_W'(1);
                    if (err_d && ctl_stop_on_err) begin
                        state_d   = HALT;
                        stopped_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
            end
        endcase

        if (ctl_soft_reset) begin
            state_d    = IDLE;
            rd_vld_d   = 1'b0;
            wr_vld_d   = 1'b0;
            src_d      = '0;
            dst_d      = '0;
            len_d      = '0;
            rd_flag_d  = 1'b0;
            wr_flag_d  = 1'b0;
            err_d      = 1'b0;
            count_d    = '0;
            stopped_d  = 1'b0;
            overflow_d = 1'b0;
            pop        = 1'b0;
        end
    end

    assign busy_d = ~ctl_soft_reset & ((state_d != IDLE) | (level_next_c != '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rd_cmd_valid     <= 1'b0;
            wr_cmd_valid     <= 1'b0;
            cmd_src          <= '0;
            cmd_dst          <= '0;
            cmd_len          <= '0;
            rd_flag          <= 1'b0;
            wr_flag          <= 1'b0;
            err_flag         <= 1'b0;
            desc_count       <= '0;
            stopped_on_error <= 1'b0;
            overflow         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_d;
            rd_cmd_valid     <= rd_vld_d;
            wr_cmd_valid     <= wr_vld_d;
            cmd_src          <= src_d;
            cmd_dst          <= dst_d;
            cmd_len          <= len_d;
            rd_flag          <= rd_flag_d;
            wr_flag          <= wr_flag_d;
            err_flag         <= err_d;
            desc_count       <= count_d;
            stopped_on_error <= stopped_d;
            overflow         <= overflow_d;
            busy             <= busy_d;
        end
    end

`ifdef DMA_DISPATCHER_PERF_CNTR_EN
    logic [31:0] perf_d;

    // Counts cycles of the in-flight descriptor; frozen once back in IDLE or HALT.
    always_comb begin
        perf_d = perf_cycles;
        if (pop) begin
            perf_d = '0;
        end else if ((state == ISSUE || state == WAIT_DONE) && perf_cycles != '1) begin
            perf_d = perf_cycles + 32'd1;
        end
        if (ctl_soft_reset) begin
            perf_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
        end else begin
            perf_cycles <= perf_d;
        end
    end
`endif

endmodule

// File: tb/tb_dma_dispatcher.sv
// Randomized bench for dma_dispatcher: emulated read/write engines, a descriptor-queue
// reference model updated on each clock edge, and per-cycle comparison on the falling edge.
module tb_dma_dispatcher;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] len;
    } desc_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             desc_go = 1'b0;
    logic [63:0]      desc_src = '0;
    logic [63:0]      desc_dst = '0;
    logic [31:0]      desc_len = '0;
    logic             ctl_stop = 1'b0;
    logic             ctl_soft_reset = 1'b0;
    logic             ctl_stop_on_err = 1'b0;
    logic             rd_cmd_valid, wr_cmd_valid;
    logic             rd_cmd_ready = 1'b0;
    logic             wr_cmd_ready = 1'b0;
    logic [63:0]      cmd_src, cmd_dst;
    logic [31:0]      cmd_len;
    logic             rd_done = 1'b0;
    logic             wr_done = 1'b0;
    logic             rd_err = 1'b0;
    logic             wr_err = 1'b0;
    logic             busy, fifo_empty, fifo_full;
    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] desc_count;
    logic             stopped_on_error, overflow;
    logic [1:0]       state;

    dma_dispatcher #(
        .ADDR_W(64), .LEN_W(32), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .desc_go(desc_go), .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
        .ctl_stop(ctl_stop), .ctl_soft_reset(ctl_soft_reset), .ctl_stop_on_err(ctl_stop_on_err),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_done(rd_done), .wr_done(wr_done), .rd_err(rd_err), .wr_err(wr_err),
        .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .desc_count(desc_count), .stopped_on_error(stopped_on_error), .overflow(overflow),
        .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Reference model: a queue of pending descriptors plus the one in flight.
    desc_t m_q[$];
    desc_t m_cur = '0;
    int    m_phase = 0;             // 0 idle, 1 commands outstanding, 2 awaiting done, 3 halted
    bit    m_rpend = 0, m_wpend = 0;  // command not yet accepted
    bit    m_rgot = 0, m_wgot = 0;    // completion seen
    bit    m_err = 0, m_halt = 0, m_ovf = 0;
    int    m_count = 0;

    task automatic model_clear();
        m_q.delete();
        m_cur   = '0;
        m_phase = 0;
        m_rpend = 0; m_wpend = 0; m_rgot = 0; m_wgot = 0;
        m_err   = 0; m_halt = 0; m_ovf = 0; m_count = 0;
    endtask

    initial begin
        forever begin
            int sz;
            @(posedge clk or negedge reset_n);
            if (!reset_n || ctl_soft_reset) begin
                model_clear();
            end else begin
                sz = m_q.size();
                if (m_phase == 0) begin
                    if (sz > 0 && !ctl_stop && !m_halt) begin
                        m_cur   = m_q.pop_front();
                        m_rpend = 1; m_wpend = 1; m_rgot = 0; m_wgot = 0; m_err = 0;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (!m_rpend && rd_done) begin m_rgot = 1; m_err |= rd_err; end
                    if (!m_wpend && wr_done) begin m_wgot = 1; m_err |= wr_err; end
                    if (rd_cmd_ready) m_rpend = 0;
                    if (wr_cmd_ready) m_wpend = 0;
                    if (!m_rpend && !m_wpend) m_phase = 2;
                end else if (m_phase == 2) begin
                    if (rd_done) begin m_rgot = 1; m_err |= rd_err; end
                    if (wr_done) begin m_wgot = 1; m_err |= wr_err; end
                    if (m_rgot && m_wgot) begin
                        m_count++;
                        if (m_err && ctl_stop_on_err) begin
                            m_phase = 3;
                            m_halt  = 1;
                        end else begin
                            m_phase = 0;
                        end
                    end
                end
                if (desc_go) begin
                    if (sz >= DEPTH) m_ovf = 1;
                    else m_q.push_back(desc_t'{desc_src, desc_dst, desc_len});
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (!cmp_en) return;
        chk("state", 64'(state), 64'(m_phase));
        chk("rd_cmd_valid", 64'(rd_cmd_valid), 64'(m_phase == 1 && m_rpend));
        chk("wr_cmd_valid", 64'(wr_cmd_valid), 64'(m_phase == 1 && m_wpend));
        if (m_phase == 1) begin
            chk("cmd_src", cmd_src, m_cur.src);
            chk("cmd_dst", cmd_dst, m_cur.dst);
            chk("cmd_len", 64'(cmd_len), 64'(m_cur.len));
        end
        chk("busy", 64'(busy), 64'(m_phase != 0 || m_q.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        chk("fifo_empty", 64'(fifo_empty), 64'(m_q.size() == 0));
        chk("fifo_full", 64'(fifo_full), 64'(m_q.size() == DEPTH));
        chk("desc_count", 64'(desc_count), 64'(m_count % (1 << CNT_W)));
        chk("stopped_on_error", 64'(stopped_on_error), 64'(m_halt));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // Engine emulation knobs.
    bit ready_rand = 0;
    int rd_delay = 0, wr_delay = 0;
    int done_fixed = 5;
    bit err_rand = 0;
    bit wr_err_once = 0;
    int rd_cnt = 0, wr_cnt = 0, rd_hold = 0, wr_hold = 0;
    bit rd_v_prev = 0, wr_v_prev = 0;
    int rd_vcyc = 0, wr_vcyc = 0;

    task automatic engine_step();
        rd_done = 0; rd_err = 0; wr_done = 0; wr_err = 0;
        if (!reset_n) begin
            rd_cnt = 0; wr_cnt = 0;
        end else begin
            if (rd_v_prev && rd_cmd_ready) rd_cnt = (done_fixed > 0) ? done_fixed : int'($urandom_range(1, 6));
            if (wr_v_prev && wr_cmd_ready) wr_cnt = (done_fixed > 0) ? done_fixed : int'($urandom_range(1, 6));
            if (rd_cnt == 1) begin
                rd_done = 1;
                rd_err  = err_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (wr_cnt == 1) begin
                wr_done = 1;
                if (wr_err_once) begin
                    wr_err = 1; wr_err_once = 0;
                end else begin
                    wr_err = err_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
                end
            end
            if (rd_cnt > 0) rd_cnt--;
            if (wr_cnt > 0) wr_cnt--;
        end
        if (rd_cmd_valid) rd_vcyc++; else rd_hold = 0;
        if (wr_cmd_valid) wr_vcyc++; else wr_hold = 0;
        if (ready_rand) rd_cmd_ready = $urandom_range(0, 1) != 0;
        else if (rd_cmd_valid && rd_hold < rd_delay) begin rd_cmd_ready = 0; rd_hold++; end
        else rd_cmd_ready = 1;
        if (ready_rand) wr_cmd_ready = $urandom_range(0, 1) != 0;
        else if (wr_cmd_valid && wr_hold < wr_delay) begin wr_cmd_ready = 0; wr_hold++; end
        else wr_cmd_ready = 1;
        rd_v_prev = rd_cmd_valid;
        wr_v_prev = wr_cmd_valid;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        engine_step();
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
        desc_go = 1; desc_src = s; desc_dst = d; desc_len = l;
        tick();
        desc_go = 0;
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            desc_go  = 1;
            desc_src = {$urandom, $urandom};
            desc_dst = {$urandom, $urandom};
            desc_len = $urandom;
            tick();
        end
        desc_go = 0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin tick(); n++; end
        chk(name, 64'(busy), 64'(0));
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int maxc);
        int n = 0;
        while (state !== st && n < maxc) begin tick(); n++; end
        chk(name, 64'(state), 64'(st));
    endtask

    task automatic soft_reset_pulse();
        ctl_soft_reset = 1;
        tick();
        ctl_soft_reset = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_fifo_empty", 64'(fifo_empty), 64'(1));
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_count", 64'(desc_count), 64'(0));
        reset_n = 1;
        cmp_en  = 1;
        tick();

        // Single descriptor: command appears two cycles after go
        push(64'h1000, 64'h2000, 32'h40);
        chk("t1_lat1_valid", 64'(rd_cmd_valid), 64'(0));
        tick();
        chk("t1_rd_valid", 64'(rd_cmd_valid), 64'(1));
        chk("t1_wr_valid", 64'(wr_cmd_valid), 64'(1));
        chk("t1_src", cmd_src, 64'h1000);
        chk("t1_dst", cmd_dst, 64'h2000);
        chk("t1_len", 64'(cmd_len), 64'h40);
        wait_idle("t1_idle", 40);
        chk("t1_count", 64'(desc_count), 64'(1));
        chk("t1_state", 64'(state), 64'(0));

        // Staggered handshake
        rd_delay = 3; rd_vcyc = 0; wr_vcyc = 0;
        push(64'hdead_0000, 64'hbeef_0000, 32'h123);
        wait_idle("t2_idle", 40);
        chk("t2_rd_valid_cycles", 64'(rd_vcyc), 64'(4));
        chk("t2_wr_valid_cycles", 64'(wr_vcyc), 64'(1));
        chk("t2_count", 64'(desc_count), 64'(2));
        rd_delay = 0;

        // Fill while stopped, then drain in order
        ctl_stop = 1;
        push_burst(DEPTH + 1);
        tick();
        chk("t3_level", 64'(fifo_level), 64'(16));
        chk("t3_full", 64'(fifo_full), 64'(1));
        chk("t3_overflow", 64'(overflow), 64'(1));
        chk("t3_no_cmd", 64'(rd_cmd_valid | wr_cmd_valid), 64'(0));
        ready_rand = 1; done_fixed = 0;
        ctl_stop = 0;
        wait_idle("t3_drain", 2000);
        chk("t3_count", 64'(desc_count), 64'(18 % 16));

        // Error halt on the first of three descriptors
        ctl_stop = 1; ctl_stop_on_err = 1;
        push_burst(3);
        wr_err_once = 1;
        ctl_stop = 0;
        wait_state("t4_halt_state", 2'd3, 300);
        repeat (3) tick();
        chk("t4_stopped", 64'(stopped_on_error), 64'(1));
        chk("t4_level", 64'(fifo_level), 64'(2));
        chk("t4_state_held", 64'(state), 64'(3));
        soft_reset_pulse();
        chk("t4_sr_empty", 64'(fifo_empty), 64'(1));
        chk("t4_sr_state", 64'(state), 64'(0));
        chk("t4_sr_count", 64'(desc_count), 64'(0));
        chk("t4_sr_stopped", 64'(stopped_on_error), 64'(0));
        chk("t4_sr_overflow", 64'(overflow), 64'(0));
        ctl_stop_on_err = 0;

        // Asynchronous reset while awaiting completion
        ready_rand = 0; done_fixed = 6;
        ctl_stop = 1;
        push_burst(5);
        ctl_stop = 0;
        wait_state("t5_wait_done", 2'd2, 50);
        chk("t5_level", 64'(fifo_level), 64'(4));
        #2 reset_n = 0;
        #1;
        chk("t5_rst_empty", 64'(fifo_empty), 64'(1));
        chk("t5_rst_level", 64'(fifo_level), 64'(0));
        chk("t5_rst_state", 64'(state), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_valid", 64'(rd_cmd_valid | wr_cmd_valid), 64'(0));
        tick();
        reset_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_post_no_valid", 64'(rd_cmd_valid | wr_cmd_valid), 64'(0));
        end

        // Random traffic with ignored errors and stop toggling
        ready_rand = 1; done_fixed = 0; err_rand = 1;
        for (int i = 0; i < 600; i++) begin
            desc_go  = ($urandom_range(0, 3) == 0);
            desc_src = {$urandom, $urandom};
            desc_dst = {$urandom, $urandom};
            desc_len = $urandom;
            if ($urandom_range(0, 19) == 0) ctl_stop = ~ctl_stop;
            tick();
        end
        desc_go = 0; ctl_stop = 0;
        wait_idle("t6_drain", 3000);
        chk("t6_no_halt", 64'(stopped_on_error), 64'(0));

        // Counter wrap with a 4-bit count
        err_rand = 0; ready_rand = 0; done_fixed = 2;
        soft_reset_pulse();
        for (int i = 0; i < 17; i++) begin
            push({$urandom, $urandom}, {$urandom, $urandom}, $urandom);
            wait_idle("t7_idle", 50);
        end
        chk("t7_wrap_count", 64'(desc_count), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
